patch_streamer: RTL and testbench
=================================

# patch_streamer

Downstream stage of the patchifier in the ViT front end. Captures the patchifier's parallel patch array when the patchifier reports output-ready (state `2'b10`) and acknowledges it with a one-cycle `output_taken` pulse. Then serialises the patches one pixel per beat, patch-major, over a valid/ready stream to the embedding stage. Optionally prepends a class-token patch.

## Interface
Parameters:
- CHANNEL_SIZE, 8, bits per colour channel
- NUM_CHANNELS, 3, channels per pixel
- PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, pixel word width
- IMG_WIDTH, 4, image width in pixels
- IMG_HEIGHT, 4, image height in pixels
- PATCH_SIZE, 2, patch edge in pixels
- TOTAL_NUM_PATCHES, (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE), image patches
- PATCH_VECTOR_SIZE, PATCH_SIZE*PATCH_SIZE, pixels per patch
- NUM_OUT_PATCHES, TOTAL_NUM_PATCHES (+1 with CLS_TOKEN_EN), emitted patches
- PIDX_W, $clog2(NUM_OUT_PATCHES), patch index width (min 1)
- POS_W, $clog2(PATCH_VECTOR_SIZE), position index width (min 1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_state  in  2  patchifier state (`00` idle, `01` busy, `10` output ready)
- all_patches  in  PIXEL_WIDTH x [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE]  patchifier output array
- output_taken  out  1  one-cycle acknowledge to the patchifier
- cls_token  in  PIXEL_WIDTH  class-token pixel value (port exists only with CLS_TOKEN_EN)
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accept
- out_pixel  out  PIXEL_WIDTH  beat data
- out_patch_idx  out  PIDX_W  emitted patch index
- out_pos_idx  out  POS_W  position within the patch
- out_last  out  1  final beat of the frame
- busy  out  1  high whenever not IDLE
- frame_done  out  1  one-cycle pulse after the final handshake

## Operation
- FSM has two states:
  - IDLE: if in_state==`2'b10`, capture all_patches into an internal buffer, zero both counters, go to STREAM. Otherwise stay in IDLE.
  - STREAM: out_valid=1. A handshake is out_valid&&out_ready. On each handshake, pos_cnt increments. When pos_cnt wraps from PATCH_VECTOR_SIZE-1 to 0, patch_cnt increments. A handshake on the final beat returns to IDLE.
- out_pixel = buffer[patch_cnt][pos_cnt]. With CLS_TOKEN_EN, patch 0 outputs cls_token and buffer patch k is emitted as patch k+1.
- out_patch_idx = patch_cnt; out_pos_idx = pos_cnt. out_last = STREAM && patch_cnt==NUM_OUT_PATCHES-1 && pos_cnt==PATCH_VECTOR_SIZE-1.
- Beats per frame = NUM_OUT_PATCHES*PATCH_VECTOR_SIZE (defaults: 16, or 20 with CLS).
- in_state is ignored in STREAM. No new capture happens until back in IDLE.
- out_pixel, out_patch_idx, out_pos_idx and out_last hold stable while out_valid && !out_ready.
- All outputs are 0 when not in STREAM, except output_taken, busy and frame_done.

## Timing
- Reset values: FSM=IDLE; counters=0; output_taken=0; out_valid=0; out_last=0; busy=0; frame_done=0. Buffer contents are don't-care.
- Capture at edge E when IDLE && in_state==`10`:
  - output_taken is registered and high for exactly the cycle after E.
  - The patchifier clears its array at the end of that cycle; the buffer already holds the data.
- First out_valid is in the cycle after E. With out_ready held high, the frame takes one beat per cycle: 16 cycles (default) or 20 (CLS).
- frame_done is a registered pulse in the cycle after the final handshake. FSM is IDLE in that same cycle.
- Earliest next capture is the cycle after the final handshake.
- Back-to-back frames: in_state==`10` already present when IDLE is re-entered is captured immediately.
- Reset mid-STREAM: return to IDLE next cycle with all outputs at reset values. A pending output_taken pulse is squashed.
- out_ready low for any duration: no beat is lost or duplicated.

## Configuration
- CLS_TOKEN_EN defined:
  - cls_token port exists.
  - NUM_OUT_PATCHES = TOTAL_NUM_PATCHES+1; patch 0 carries cls_token at every position.
- CLS_TOKEN_EN undefined:
  - No cls_token port.
  - NUM_OUT_PATCHES = TOTAL_NUM_PATCHES; image patches are emitted from index 0.

## Structure
- Shared package `patch_pkg`:
  - patchifier state encodings PATCHIFIER_IDLE=`2'b00`, PATCHIFIER_BUSY=`2'b01`, PATCHIFIER_READY=`2'b10`
  - streamer FSM enum
  - pixel typedef of PIXEL_WIDTH bits
- One sub-module, `patch_beat_counter`: nested pos/patch counter with enable, synchronous clear, wrap, and a last flag. Its parameters are the two limits.

## Test plan
- Basic frame: all_patches[p][q]=24'h0000{p}{q}, in_state=`10` for 2 cycles, out_ready=1 → output_taken high exactly 1 cycle; 16 beats in order 24'h000000, 24'h000001 … 24'h000033; out_last on beat 16; frame_done 1 cycle later.
- Backpressure: toggle out_ready every cycle → still exactly 16 beats in order; data and indices stable during stalls.
- Capture isolation: change all_patches to 24'hFFFFFF one cycle after capture → streamed data unchanged.
- Back-to-back: in_state=`10` present when the first frame_done pulses → second capture within 1 cycle; two output_taken pulses in total.
- Reset mid-stream: reset at beat 7 → next cycle out_valid=0, busy=0, output_taken=0; a fresh capture afterwards starts at patch 0, pos 0.
- CLS_TOKEN_EN with cls_token=24'hABCDEF → first 4 beats 24'hABCDEF with patch_idx 0; then the image data with patch_idx 1–4; 20 beats total.

Source files
------------

// File: rtl/patch_pkg.sv
// Shared definitions for the patchifier / patch streamer pair.
// Optional class-token support is selected in the streamer with CLS_TOKEN_EN.
package patch_pkg;

   localparam logic [1:0] PATCHIFIER_IDLE  = 2'b00;
   localparam logic [1:0] PATCHIFIER_BUSY  = 2'b01;
   localparam logic [1:0] PATCHIFIER_READY = 2'b10;

   localparam int unsigned DEF_PIXEL_WIDTH = 24;

   typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } stream_state_t;

   // Index width for a counter covering n values, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/patch_beat_counter.sv
// Nested position/patch counter: position wraps at POS_LIMIT and carries into
// the patch count, which wraps at PATCH_LIMIT. o_last flags the final beat.
module patch_beat_counter
   import patch_pkg::*;
#(
   parameter  int unsigned POS_LIMIT   = 4,
   parameter  int unsigned PATCH_LIMIT = 4,
   localparam int unsigned POS_W       = idx_width(POS_LIMIT),
   localparam int unsigned PIDX_W      = idx_width(PATCH_LIMIT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clr,
   input  logic              i_en,
   output logic [POS_W-1:0]  o_pos,
   output logic [PIDX_W-1:0] o_patch,
   output logic              o_last
);

   logic [POS_W-1:0]  r_pos;
   logic [PIDX_W-1:0] r_patch;
   logic              w_pos_wrap;
   logic              w_patch_wrap;

   assign w_pos_wrap   = (r_pos == POS_W'(POS_LIMIT - 1));
   assign w_patch_wrap = (r_patch == PIDX_W'(PATCH_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_pos   <= '0;
         r_patch <= '0;
      end else if (i_en) begin
         if (w_pos_wrap) begin
            r_pos   <= '0;
            r_patch <= w_patch_wrap ? '0 : r_patch + 1'b1;
         end else begin
            r_pos <= r_pos + 1'b1;
         end
      end
   end

   assign o_pos   = r_pos;
   assign o_patch = r_patch;
   assign o_last  = w_pos_wrap && w_patch_wrap;

endmodule

// File: rtl/patch_streamer.sv
// Captures the patchifier's patch array and streams it one pixel per beat,
// patch-major. Define CLS_TOKEN_EN to prepend a class-token patch.
module patch_streamer
   import patch_pkg::*;
#(
   parameter int unsigned CHANNEL_SIZE      = 8,
   parameter int unsigned NUM_CHANNELS      = 3,
   parameter int unsigned PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
   parameter int unsigned IMG_WIDTH         = 4,
   parameter int unsigned IMG_HEIGHT        = 4,
   parameter int unsigned PATCH_SIZE        = 2,
   parameter int unsigned TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
   parameter int unsigned PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
`ifdef CLS_TOKEN_EN
   parameter int unsigned NUM_OUT_PATCHES   = TOTAL_NUM_PATCHES + 1,
`else
   parameter int unsigned NUM_OUT_PATCHES   = TOTAL_NUM_PATCHES,
`endif
   parameter int unsigned PIDX_W            = idx_width(NUM_OUT_PATCHES),
   parameter int unsigned POS_W             = idx_width(PATCH_VECTOR_SIZE)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             in_state,
   input  logic [PIXEL_WIDTH-1:0] all_patches [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE],
   output logic                   output_taken,
`ifdef CLS_TOKEN_EN
   input  logic [PIXEL_WIDTH-1:0] cls_token,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PIXEL_WIDTH-1:0] out_pixel,
   output logic [PIDX_W-1:0]      out_patch_idx,
   output logic [POS_W-1:0]       out_pos_idx,
   output logic                   out_last,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int unsigned IMG_W = idx_width(TOTAL_NUM_PATCHES);

   stream_state_t          r_state;
   stream_state_t          w_next;
   logic [PIXEL_WIDTH-1:0] r_buf [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE];
   logic                   r_output_taken;
   logic                   r_frame_done;
   logic                   w_stream;
   logic                   w_capture;
   logic                   w_hs;
   logic                   w_last;
   logic [POS_W-1:0]       w_pos;
   logic [PIDX_W-1:0]      w_patch;
   logic [IMG_W-1:0]       w_img_idx;
   logic [PIXEL_WIDTH-1:0] w_pix;

   assign w_stream  = (r_state == ST_STREAM);
   assign w_capture = (r_state == ST_IDLE) && (in_state == PATCHIFIER_READY);
   assign w_hs      = w_stream && out_ready;

   patch_beat_counter #(
      .POS_LIMIT   (PATCH_VECTOR_SIZE),
      .PATCH_LIMIT (NUM_OUT_PATCHES)
   ) u_beat_counter (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_capture),
      .i_en    (w_hs),
      .o_pos   (w_pos),
      .o_patch (w_patch),
      .o_last  (w_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_output_taken <= 1'b0;
         r_frame_done   <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_output_taken <= w_capture;
         r_frame_done   <= w_hs && w_last;
      end
   end

   // Buffer has no reset: its contents only matter after a capture.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_buf <= all_patches;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_capture)      w_next = ST_STREAM;
         ST_STREAM: if (w_hs && w_last) w_next = ST_IDLE;
         default:                       w_next = ST_IDLE;
      endcase
   end

`ifdef CLS_TOKEN_EN
   assign w_img_idx = IMG_W'(w_patch - 1'b1);
   assign w_pix     = (w_patch == '0) ? cls_token : r_buf[w_img_idx][w_pos];
`else
   assign w_img_idx = IMG_W'(w_patch);
   assign w_pix     = r_buf[w_img_idx][w_pos];
`endif

   always_comb begin
      out_valid     = 1'b0;
      out_pixel     = '0;
      out_patch_idx = '0;
      out_pos_idx   = '0;
      out_last      = 1'b0;
      if (w_stream) begin
         out_valid     = 1'b1;
         out_pixel     = w_pix;
         out_patch_idx = w_patch;
         out_pos_idx   = w_pos;
         out_last      = w_last;
      end
   end

   assign output_taken = r_output_taken;
   assign busy         = w_stream;
   assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_patch_streamer.sv
// Directed bench for patch_streamer: basic frame, backpressure, capture
// isolation, back-to-back frames and resets; honours CLS_TOKEN_EN.
module tb_patch_streamer;
   import patch_pkg::*;

   localparam int unsigned NP = 4;
   localparam int unsigned NV = 4;
`ifdef CLS_TOKEN_EN
   localparam int unsigned NCLS    = 1;
   localparam pixel_t      CLS_VAL = 24'hABCDEF;
`else
   localparam int unsigned NCLS    = 0;
`endif
   localparam int unsigned NOUT      = NP + NCLS;
   localparam int unsigned NBEATS    = NOUT * NV;
   localparam int unsigned PIDX_W    = idx_width(NOUT);
   localparam int unsigned POS_W     = idx_width(NV);
   localparam int unsigned NO_ABORT  = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        in_state = PATCHIFIER_IDLE;
   pixel_t            tb_patches [NP][NV];
   pixel_t            exp_img    [NP][NV];
   logic              out_ready = 1'b1;
   logic              output_taken;
   logic              out_valid;
   pixel_t            out_pixel;
   logic [PIDX_W-1:0] out_patch_idx;
   logic [POS_W-1:0]  out_pos_idx;
   logic              out_last;
   logic              busy;
   logic              frame_done;

   int n_checks = 0;
   int n_err    = 0;

   patch_streamer dut (
      .clk           (clk),
      .reset         (reset),
      .in_state      (in_state),
      .all_patches   (tb_patches),
      .output_taken  (output_taken),
`ifdef CLS_TOKEN_EN
      .cls_token     (CLS_VAL),
`endif
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pixel     (out_pixel),
      .out_patch_idx (out_patch_idx),
      .out_pos_idx   (out_pos_idx),
      .out_last      (out_last),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_image(input bit ones, input logic [7:0] base);
      for (int p = 0; p < NP; p++) begin
         for (int q = 0; q < NV; q++) begin
            pixel_t v;
            v = ones ? 24'hFFFFFF : {8'h00, base, p[3:0], q[3:0]};
            tb_patches[p][q] = v;
            if (!ones) exp_img[p][q] = v;
         end
      end
   endtask

   function automatic pixel_t exp_pix(input int unsigned p, input int unsigned q);
`ifdef CLS_TOKEN_EN
      if (p == 0) return CLS_VAL;
`endif
      return exp_img[p - NCLS][q];
   endfunction

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"},  32'(out_valid), 0);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_taken"},  32'(output_taken), 0);
      chk({tag, "_last"},   32'(out_last), 0);
      chk({tag, "_pixel"},  32'(out_pixel), 0);
      chk({tag, "_pidx"},   32'(out_patch_idx), 0);
      chk({tag, "_pos"},    32'(out_pos_idx), 0);
   endtask

   // Called right after the capture edge has been set up; monitors one frame.
   task automatic run_frame(input bit toggle, input bit clobber, input bit b2b,
                            input int unsigned abort_beat);
      int unsigned beat = 0;
      int unsigned cyc = 0;
      int unsigned taken = 0;
      bit          stalled = 0;
      bit          aborted = 0;
      pixel_t      h_pix = '0;
      logic [31:0] h_patch = '0;
      logic [31:0] h_pos = '0;
      logic        h_last = 1'b0;
      while (beat < NBEATS && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (output_taken) taken++;
         chk("output_taken", 32'(output_taken), 32'(cyc == 1));
         chk("busy", 32'(busy), 1);
         chk("out_valid", 32'(out_valid), 1);
         chk("frame_done_mid", 32'(frame_done), 0);
         if (stalled) begin
            chk("stall_pixel", 32'(out_pixel), 32'(h_pix));
            chk("stall_pidx", 32'(out_patch_idx), h_patch);
            chk("stall_pos", 32'(out_pos_idx), h_pos);
            chk("stall_last", 32'(out_last), 32'(h_last));
         end
         chk("pixel", 32'(out_pixel), 32'(exp_pix(beat / NV, beat % NV)));
         chk("patch_idx", 32'(out_patch_idx), beat / NV);
         chk("pos_idx", 32'(out_pos_idx), beat % NV);
         chk("out_last", 32'(out_last), 32'(beat == NBEATS - 1));
         if (beat == abort_beat) begin
            reset = 1'b1;
            aborted = 1;
            break;
         end
         if (cyc == 2) in_state = PATCHIFIER_IDLE;
         if (clobber && cyc == 1) load_image(1, 8'h00);
         out_ready = toggle ? ~out_ready : 1'b1;
         if (out_ready) begin
            beat++;
            stalled = 0;
         end else begin
            stalled = 1;
            h_pix   = out_pixel;
            h_patch = 32'(out_patch_idx);
            h_pos   = 32'(out_pos_idx);
            h_last  = out_last;
         end
         if (b2b && beat == NBEATS) begin
            in_state = PATCHIFIER_READY;
            load_image(0, 8'h5A);
         end
      end
      if (!aborted) begin
         chk("beats_in_budget", beat, NBEATS);
         chk("taken_pulses", taken, 1);
         if (!toggle) chk("frame_cycles", cyc, NBEATS);
         @(negedge clk);
         chk("frame_done_pulse", 32'(frame_done), 1);
         chk_idle_outputs("after_frame");
         if (!b2b) begin
            @(negedge clk);
            chk("frame_done_single", 32'(frame_done), 0);
         end
      end
   endtask

   initial begin
      load_image(0, 8'h00);
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      chk("reset_done", 32'(frame_done), 0);
      reset = 1'b0;

      in_state = PATCHIFIER_BUSY;
      @(negedge clk);
      chk_idle_outputs("busy_ignored");

      // Basic frame
      in_state = PATCHIFIER_READY;
      run_frame(0, 0, 0, NO_ABORT);

      // Backpressure
      in_state = PATCHIFIER_READY;
      run_frame(1, 0, 0, NO_ABORT);
      out_ready = 1'b1;

      // Capture isolation
      load_image(0, 8'h00);
      in_state = PATCHIFIER_READY;
      run_frame(0, 1, 0, NO_ABORT);

      // Back-to-back: second image captured when the first frame_done pulses
      load_image(0, 8'h00);
      in_state = PATCHIFIER_READY;
      run_frame(0, 0, 1, NO_ABORT);
      run_frame(0, 0, 0, NO_ABORT);

      // Reset mid-stream at beat 7
      load_image(0, 8'h21);
      in_state = PATCHIFIER_READY;
      run_frame(0, 0, 0, 7);
      @(negedge clk);
      chk_idle_outputs("mid_reset");
      chk("mid_reset_done", 32'(frame_done), 0);
      reset = 1'b0;

      // Reset coinciding with a capture request squashes the acknowledge
      in_state = PATCHIFIER_READY;
      reset = 1'b1;
      @(negedge clk);
      chk_idle_outputs("squash");
      reset = 1'b0;
      run_frame(0, 0, 0, NO_ABORT);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
